fp_mul_booth_seq: RTL

- Iterative radix-4 Booth mantissa multiplier for the single-precision FP multiply path.
- Computes the full 48-bit significand product {1,frc_X}*{1,frc_Y}, one Booth digit per cycle.
- Presents the product to the normalization stage as frc_Z_full, with valid/ready handshakes on both sides.
- Carries an opaque sideband tag (sign, exponent sum, r_mode) aligned with the product so the downstream norm/round/exponent stages stay in step.

---
 rtl/fp_mul_booth_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_booth_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_booth_seq
//
// Iterative radix-4 Booth significand multiplier for the single-precision
// FP multiply path. It forms the exact 48-bit product {1,frc_X}*{1,frc_Y} and
// retires one Booth digit per clock. An opaque sideband tag travels with each
// operation, so the downstream normalize/round/exponent stages stay aligned.
//
// Ports
//   clk         clock; every state update happens on its rising edge
//   rst_n       synchronous active-low reset
//   flush       synchronous abort; any in-flight result is dropped
//   in_valid    operand pair is valid
//   in_ready    block can accept operands (combinational from out_ready)
//   frc_X       multiplicand fraction (hidden bit implied 1)
//   frc_Y       multiplier fraction (hidden bit implied 1)
//   in_tag      sideband, captured when operands are accepted
//   out_valid   frc_Z_full / out_tag hold a valid result
//   out_ready   downstream consumes the result
//   frc_Z_full  unsigned 2*(FRAC_W+1)-bit product
//   out_tag     tag captured with this operation
//   busy        high while digits are being accumulated
// ---------------------------------------------------------------------------
module fp_mul_booth_seq #(
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FRAC_W-1:0]      frc_X,
  input  logic [FRAC_W-1:0]      frc_Y,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*FRAC_W+1:0]    frc_Z_full,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  // Significand width including the hidden bit, and the product width.
  localparam int MW     = FRAC_W + 1;
  localparam int PROD_W = 2 * MW;
  // Unsigned multiplier needs one extra zero bit on top, hence MW+1 bits
  // split into radix-4 digits.
  localparam int NDIG   = (MW + 2) / 2;
  // Signed accumulator: two bits of headroom above the product.
  localparam int ACC_W  = PROD_W + 2;
  // Multiplier register: two zero bits, hidden bit, fraction, Booth guard.
  localparam int B_W    = MW + 3;
  localparam int CNT_W  = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   a_reg;     // multiplicand, pre-shifted by 2k
  logic [B_W-1:0]     b_reg;     // multiplier, shifted so bits [2:0] are the current triplet
  logic [CNT_W-1:0]   cnt_reg;

  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_next;
  logic               accept;
  logic               last_digit;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign accept    = in_valid && in_ready;
  assign last_digit = (cnt_reg == CNT_W'(NDIG - 1));

  // Booth recoding of triplet {b[2k+1], b[2k], b[2k-1]}. Negative digits
  // use two's complement of the (already shifted) multiplicand, so the
  // accumulator can temporarily go negative; it ends non-negative because
  // the multiplier's top digit is always positive.
  always_comb begin
    pp = '0;
    case (b_reg[2:0])
      3'b001, 3'b010: pp = a_reg;
      3'b011:         pp = a_reg << 1;
      3'b100:         pp = -(a_reg << 1);
      3'b101, 3'b110: pp = -a_reg;
      default:        pp = '0;
    endcase
  end

  assign acc_next = acc_reg + pp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      frc_Z_full <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      // frc_Z_full deliberately keeps its last value; out_valid drops with
      // the state, which is all the downstream looks at.
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        BUSY: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          a_reg   <= a_reg << 2;
          b_reg   <= b_reg >> 2;
          if (last_digit) begin
            state_reg  <= DONE;
            frc_Z_full <= acc_next[PROD_W-1:0];
            // Product of two significands never exceeds PROD_W bits.
            assert (acc_next[ACC_W-1:PROD_W] == '0);
          end
        end
        IDLE, DONE: begin
          // In DONE, accept implies out_ready, so the held result is
          // consumed on the same edge that the new operands are taken.
          if (accept) begin
            state_reg <= BUSY;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            a_reg     <= {{(ACC_W-MW){1'b0}}, 1'b1, frc_X};
            b_reg     <= {2'b00, 1'b1, frc_Y, 1'b0};
            out_tag   <= in_tag;
          end else if ((state_reg == DONE) && out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
